// File: rtl/aes_dec_pkg.sv
// Shared definitions for the AES decryption datapath stages.
//   - FSM state encodings used by the round stages
//   - word / byte widths and column count
//   - GF(2^8) reduction constant and the xtime helper
package aes_dec_pkg;

  localparam int WORD_W   = 32;
  localparam int BYTE_W   = 8;
  localparam int NUM_COLS = 4;

  // Low byte of the AES field polynomial x^8 + x^4 + x^3 + x + 1.
  localparam logic [BYTE_W-1:0] AES_RED = 8'h1B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MIX  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Multiply by x (0x02) in GF(2^8); reduce when the top bit shifts out.
  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] shifted;
    shifted = {b[BYTE_W-2:0], 1'b0};
    return b[BYTE_W-1] ? (shifted ^ AES_RED) : shifted;
  endfunction

endpackage

// File: rtl/inv_mixcol_word.sv
// InvMixColumns applied to a single 32-bit column (purely combinational).
// Ports:
//   i_col  - input column, [31:24]=row0 ... [7:0]=row3
//   o_col  - transformed column, same layout
// Each product is built from the x2/x4/x8 xtime chain of the input byte:
//   09 = x8^x1, 0b = x8^x2^x1, 0d = x8^x4^x1, 0e = x8^x4^x2
module inv_mixcol_word
  import aes_dec_pkg::*;
(
  input  logic [WORD_W-1:0] i_col,
  output logic [WORD_W-1:0] o_col
);

  logic [BYTE_W-1:0] w_a  [4];
  logic [BYTE_W-1:0] w_x2 [4];
  logic [BYTE_W-1:0] w_x4 [4];
  logic [BYTE_W-1:0] w_x8 [4];
  logic [BYTE_W-1:0] w_m9 [4];
  logic [BYTE_W-1:0] w_mb [4];
  logic [BYTE_W-1:0] w_md [4];
  logic [BYTE_W-1:0] w_me [4];
  logic [BYTE_W-1:0] w_r  [4];

  assign w_a[0] = i_col[31:24];
  assign w_a[1] = i_col[23:16];
  assign w_a[2] = i_col[15:8];
  assign w_a[3] = i_col[7:0];

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign w_x2[g] = xtime(w_a[g]);
    assign w_x4[g] = xtime(w_x2[g]);
    assign w_x8[g] = xtime(w_x4[g]);
    assign w_m9[g] = w_x8[g] ^ w_a[g];
    assign w_mb[g] = w_x8[g] ^ w_x2[g] ^ w_a[g];
    assign w_md[g] = w_x8[g] ^ w_x4[g] ^ w_a[g];
    assign w_me[g] = w_x8[g] ^ w_x4[g] ^ w_x2[g];
  end

  // Circulant matrix rows: {0e 0b 0d 09} rotated right by one per row.
  assign w_r[0] = w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3];
  assign w_r[1] = w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3];
  assign w_r[2] = w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3];
  assign w_r[3] = w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3];

  assign o_col = {w_r[0], w_r[1], w_r[2], w_r[3]};

endmodule

// File: rtl/inv_addkey_mixcol.sv
// Decryption round stage: AddRoundKey followed by InvMixColumns, one column
// per clock, with valid/ready handshakes on both sides. The final round
// skips the mix and goes straight to the output hold state.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | in_ready=1; accept a state, load w^rkey into the word register
//   MIX   | one column through InvMixColumns per edge, col 0..3
//   HOLD  | out_valid=1; result stable until out_ready
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   in_valid / in_ready   - upstream handshake
//   w0..w3, rkey0..rkey3  - column words and round-key words
//   last_round            - 1 = bypass InvMixColumns
//   out_valid / out_ready - downstream handshake
//   w_0..w_3              - result column words
module inv_addkey_mixcol
  import aes_dec_pkg::*;
#(
  parameter int NUM_COLS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] w0,
  input  logic [WORD_W-1:0] w1,
  input  logic [WORD_W-1:0] w2,
  input  logic [WORD_W-1:0] w3,
  input  logic [WORD_W-1:0] rkey0,
  input  logic [WORD_W-1:0] rkey1,
  input  logic [WORD_W-1:0] rkey2,
  input  logic [WORD_W-1:0] rkey3,
  input  logic              last_round,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] w_0,
  output logic [WORD_W-1:0] w_1,
  output logic [WORD_W-1:0] w_2,
  output logic [WORD_W-1:0] w_3
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [1:0]        r_col;
  logic [WORD_W-1:0] r_word [NUM_COLS];
  logic [WORD_W-1:0] w_keyed [NUM_COLS];
  logic [WORD_W-1:0] w_mix_in;
  logic [WORD_W-1:0] w_mix_out;

  assign w_keyed[0] = w0 ^ rkey0;
  assign w_keyed[1] = w1 ^ rkey1;
  assign w_keyed[2] = w2 ^ rkey2;
  assign w_keyed[3] = w3 ^ rkey3;

  // A single mixer shared across columns; the counter selects its operand.
  assign w_mix_in = r_word[r_col];

  inv_mixcol_word u_mix (
    .i_col (w_mix_in),
    .o_col (w_mix_out)
  );

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = last_round ? HOLD : MIX;
        end
      end
      MIX: begin
        if (r_col == 2'd3) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_col   <= 2'd0;
      for (int i = 0; i < NUM_COLS; i++) begin
        r_word[i] <= '0;
      end
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_col <= 2'd0;
            for (int i = 0; i < NUM_COLS; i++) begin
              r_word[i] <= w_keyed[i];
            end
          end
        end
        MIX: begin
          r_word[r_col] <= w_mix_out;
          // 2-bit counter wraps to 0 after column 3.
          r_col         <= r_col + 2'd1;
        end
        default: begin
        end
      endcase
    end
  end

  // Outputs come straight from the word register so they cannot glitch
  // while the downstream stage stalls.
  assign w_0 = r_word[0];
  assign w_1 = r_word[1];
  assign w_2 = r_word[2];
  assign w_3 = r_word[3];

endmodule

// File: tb/tb_inv_addkey_mixcol.sv
module tb_inv_addkey_mixcol;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rkey0, rkey1, rkey2, rkey3;
  logic        last_round;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] w_0, w_1, w_2, w_3;

  always #5 clk = ~clk;

  inv_addkey_mixcol #(.NUM_COLS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .w0         (w0),
    .w1         (w1),
    .w2         (w2),
    .w3         (w3),
    .rkey0      (rkey0),
    .rkey1      (rkey1),
    .rkey2      (rkey2),
    .rkey3      (rkey3),
    .last_round (last_round),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .w_0        (w_0),
    .w_1        (w_1),
    .w_2        (w_2),
    .w_3        (w_3)
  );

  typedef struct {
    logic [3:0][31:0] w;
    logic [3:0][31:0] k;
    logic             last;
    logic [3:0][31:0] exp;
  } vec_t;

  localparam int NVEC = 27;
  vec_t vecs [NVEC];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: generic shift-and-add GF(2^8) product and a matrix loop.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c);
    logic [7:0] coef [4];
    logic [7:0] a [4];
    logic [7:0] r [4];
    coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
    for (int i = 0; i < 4; i++) a[i] = c[31 - 8*i -: 8];
    for (int row = 0; row < 4; row++) begin
      r[row] = 8'h00;
      for (int j = 0; j < 4; j++) r[row] ^= gmul(coef[(j - row + 4) % 4], a[j]);
    end
    return {r[0], r[1], r[2], r[3]};
  endfunction

  function automatic vec_t model_vec(input logic [3:0][31:0] w, input logic [3:0][31:0] k,
                                     input logic last);
    vec_t v;
    v.w = w; v.k = k; v.last = last;
    for (int i = 0; i < 4; i++) v.exp[i] = last ? (w[i] ^ k[i]) : model_col(w[i] ^ k[i]);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    w0 = v.w[0]; w1 = v.w[1]; w2 = v.w[2]; w3 = v.w[3];
    rkey0 = v.k[0]; rkey1 = v.k[1]; rkey2 = v.k[2]; rkey3 = v.k[3];
    last_round = v.last;
  endtask

  task automatic chk_out(input string name, input vec_t v);
    chk({name, ".w_0"}, w_0, v.exp[0]);
    chk({name, ".w_1"}, w_1, v.exp[1]);
    chk({name, ".w_2"}, w_2, v.exp[2]);
    chk({name, ".w_3"}, w_3, v.exp[3]);
  endtask

  // Single transaction from IDLE with out_ready=1; checks latency and result.
  task automatic run_vec(input vec_t v, input string name);
    int lat;
    @(negedge clk);
    drive(v);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    chk({name, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
    chk({name, ".latency"}, lat, v.last ? 32'd1 : 32'd5);
    chk_out(name, v);
    @(negedge clk);
    chk({name, ".post_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({name, ".post_in_ready"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    vec_t a, b;
    int ov_seen;
    int acc, xfers;
    int acc_cyc [2];
    int xfer_cyc [2];
    vec_t seq [2];
    logic acc_now, xfer_now;

    // Directed vectors with hand-known answers.
    vecs[0].w = {32'h4d7ebdf8, 32'h01010101, 32'h9fdc589d, 32'h8e4da1bc};
    vecs[0].k = '0;
    vecs[0].last = 1'b0;
    vecs[0].exp = {32'h2d26314c, 32'h01010101, 32'hf20a225c, 32'hdb135345};

    vecs[1].w = {4{32'hffffffff}};
    vecs[1].k = {4{32'h0f0f0f0f}};
    vecs[1].last = 1'b1;
    vecs[1].exp = {4{32'hf0f0f0f0}};

    vecs[2].w = {32'h0, 32'h0, 32'h0, 32'hd5d5d7d6 ^ 32'h11223344};
    vecs[2].k = {32'h0, 32'h0, 32'h0, 32'h11223344};
    vecs[2].last = 1'b0;
    vecs[2].exp = {32'h0, 32'h0, 32'h0, 32'hd4d4d4d5};

    for (int i = 3; i < NVEC; i++) begin
      vecs[i] = model_vec({$urandom, $urandom, $urandom, $urandom},
                          {$urandom, $urandom, $urandom, $urandom},
                          ($urandom_range(0, 3) == 0));
    end

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    w0 = '0; w1 = '0; w2 = '0; w3 = '0;
    rkey0 = '0; rkey1 = '0; rkey2 = '0; rkey3 = '0; last_round = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset.out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset.w_0", w_0, 32'h0);
    chk("reset.w_3", w_3, 32'h0);
    rst = 1'b0;

    // Reset two edges after acceptance discards the state in flight.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmix.out_valid", {31'd0, out_valid}, 32'd0);
    chk("rstmix.in_ready", {31'd0, in_ready}, 32'd1);
    chk("rstmix.w_0", w_0, 32'h0);
    chk("rstmix.w_1", w_1, 32'h0);
    chk("rstmix.w_2", w_2, 32'h0);
    chk("rstmix.w_3", w_3, 32'h0);
    ov_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("rstmix.spurious", ov_seen, 32'd0);

    // Table: directed then random vectors.
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure: hold out_ready low in HOLD, offer a competing state.
    a = vecs[1];
    b = model_vec({4{32'h12345678}}, '0, 1'b1);
    @(negedge clk);
    drive(a);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 drive(b);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk($sformatf("bp%0d.out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d.in_ready", i), {31'd0, in_ready}, 32'd0);
      chk_out($sformatf("bp%0d", i), a);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp.release.out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp.release.in_ready", {31'd0, in_ready}, 32'd1);
    chk_out("bp.release", a);
    ov_seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid) ov_seen++;
    end
    chk("bp.extra_transfer", ov_seen, 32'd0);

    // Back-to-back: in_valid held high across two states.
    seq[0] = vecs[4];
    seq[0] = model_vec(seq[0].w, seq[0].k, 1'b0);
    seq[1] = model_vec({$urandom, $urandom, $urandom, $urandom},
                       {$urandom, $urandom, $urandom, $urandom}, 1'b1);
    acc = 0; xfers = 0;
    acc_cyc[0] = -100; acc_cyc[1] = -100; xfer_cyc[0] = -100; xfer_cyc[1] = -100;
    @(negedge clk);
    drive(seq[0]);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      acc_now  = in_ready && in_valid;
      xfer_now = out_valid && out_ready;
      if (xfer_now && xfers < 2) begin
        xfer_cyc[xfers] = cyc;
        chk_out($sformatf("b2b%0d", xfers), seq[xfers]);
        xfers++;
      end
      if (acc_now && acc < 2) begin
        acc_cyc[acc] = cyc;
        acc++;
      end
      if (xfers == 2) break;
      @(posedge clk);
      #1;
      if (acc_now) begin
        if (acc == 1) drive(seq[1]);
        else in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("b2b.transfers", xfers, 32'd2);
    chk("b2b.first_latency", xfer_cyc[0] - acc_cyc[0], 32'd5);
    chk("b2b.second_accept", acc_cyc[1], xfer_cyc[0] + 1);
    chk("b2b.second_latency", xfer_cyc[1] - acc_cyc[1], 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
